obstacle_spawner: RTL and testbench

- Generates the single on-screen obstacle's position, type and animation phase for the T-rex game.
- Drives the obstacle renderer's ObstacleX/ObstacleY/ObstacleSEL/animateclk inputs.
- Spawns a pseudo-randomly chosen cactus or bird at the right screen edge and scrolls it left once per video frame.
- Despawns it at the left edge, waits a random gap, then repeats. Sits between the game-control FSM and the pixel renderer.

---
 rtl/obstacle_spawner.sv | 276 +++++++++++++++++++++++++++
 tb/tb_obstacle_spawner.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
//
// Produces the one on-screen obstacle for the T-rex game: where it is, which
// sprite it uses and the bird wing phase. A pseudo-random cactus or bird
// appears at the right screen edge and scrolls left by `speed` pixels each
// video frame. When it reaches the left edge it is removed, a score pulse is
// emitted, and a pseudo-random gap of frames passes before the next spawn.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   frame_tick     in   one-cycle pulse per video frame
//   game_run       in   1 = advance on frame ticks; 0 = freeze (LFSR still runs)
//   restart        in   synchronous one-cycle clear to the post-reset state
//   speed[3:0]     in   pixels moved per frame; 0 behaves as 1
//   obstacle_x     out  obstacle left column (1023 when parked)
//   obstacle_y     out  obstacle top row
//   obstacle_sel   out  sprite select: 1000 bird, 0100 Cac1S, 0101 Cac1B,
//                       0110 Cac2S, 0111 Cac2B, 0000 none
//   obstacle_valid out  an obstacle is on screen
//   animate_clk    out  bird wing phase, toggles every ANIM_FRAMES frames
//   passed         out  one-cycle pulse when an obstacle leaves the screen
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module obstacle_spawner #(
    parameter int          SPAWN_X     = 640,
    parameter int          GROUND_Y    = 380,
    parameter int          BIRD_Y      = 200,
    parameter int          MIN_GAP     = 30,
    parameter int          ANIM_FRAMES = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       game_run,
    input  logic       restart,
    input  logic [3:0] speed,
    output logic [9:0] obstacle_x,
    output logic [9:0] obstacle_y,
    output logic [3:0] obstacle_sel,
    output logic       obstacle_valid,
    output logic       animate_clk,
    output logic       passed
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [0:0] ST_GAP    = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [3:0] SEL_NONE  = 4'b0000;
    localparam logic [3:0] SEL_BIRD  = 4'b1000;
    localparam logic [3:0] SEL_CAC1S = 4'b0100;
    localparam logic [3:0] SEL_CAC1B = 4'b0101;
    localparam logic [3:0] SEL_CAC2S = 4'b0110;
    localparam logic [3:0] SEL_CAC2B = 4'b0111;

    // Parked column is beyond every visible pixel, so the renderer never
    // matches it even if it ignores obstacle_valid.
    localparam logic [9:0] X_PARKED = 10'd1023;
    localparam logic [9:0] X_SPAWN  = 10'(SPAWN_X);
    localparam logic [9:0] Y_SMALL  = 10'(GROUND_Y - 70);
    localparam logic [9:0] Y_BIG    = 10'(GROUND_Y - 100);
    localparam logic [9:0] Y_BIRD   = 10'(BIRD_Y);

    // Gap counter must hold MIN_GAP + 63 (largest random extension).
    localparam int GAP_W  = $clog2(MIN_GAP + 65);
    localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    localparam logic [GAP_W-1:0]  GAP_MIN   = GAP_W'(MIN_GAP);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_FRAMES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0]       r_lfsr;
    logic [0:0]        r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [ANIM_W-1:0] r_anim_cnt;
    logic              r_anim;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [3:0]        r_sel;
    logic              r_valid;
    logic              r_passed;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic              w_advance;
    logic              w_lfsr_fb;
    logic [3:0]        w_step;
    logic [9:0]        w_step_x;
    logic [GAP_W-1:0]  w_gap_reload;
    logic [3:0]        w_spawn_sel;
    logic [9:0]        w_spawn_y;

    logic [0:0]        w_nxt_state;
    logic [GAP_W-1:0]  w_nxt_gap;
    logic [9:0]        w_nxt_x;
    logic [9:0]        w_nxt_y;
    logic [3:0]        w_nxt_sel;
    logic              w_nxt_valid;
    logic              w_nxt_passed;

    assign w_advance = frame_tick & game_run;

    // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // A zero speed would stall the obstacle forever; treat it as 1.
    assign w_step   = (speed == 4'd0) ? 4'd1 : speed;
    assign w_step_x = {6'd0, w_step};

    assign w_gap_reload = GAP_MIN + GAP_W'(r_lfsr[5:0]);

    // Sprite choice from the low LFSR bits. Cac1S gets two codes so small
    // cacti appear a little more often than big ones.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path can leave it unassigned and infer a latch.
        w_spawn_sel = SEL_BIRD;
        w_spawn_y   = Y_BIRD;
        case (r_lfsr[2:0])
            3'd0, 3'd1: begin
                w_spawn_sel = SEL_CAC1S;
                w_spawn_y   = Y_SMALL;
            end
            3'd2: begin
                w_spawn_sel = SEL_CAC2S;
                w_spawn_y   = Y_SMALL;
            end
            3'd3: begin
                w_spawn_sel = SEL_CAC1B;
                w_spawn_y   = Y_BIG;
            end
            3'd4: begin
                w_spawn_sel = SEL_CAC2B;
                w_spawn_y   = Y_BIG;
            end
            default: begin
                w_spawn_sel = SEL_BIRD;
                w_spawn_y   = Y_BIRD;
            end
        endcase
    end

    // Next-state logic for the spawn/scroll FSM and its output registers.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_gap    = r_gap_cnt;
        w_nxt_x      = r_x;
        w_nxt_y      = r_y;
        w_nxt_sel    = r_sel;
        w_nxt_valid  = r_valid;
        w_nxt_passed = 1'b0;

        if (w_advance) begin
            case (r_state)
                ST_GAP: begin
                    // Spawn on the tick that finds the counter already at 0,
                    // so a gap of N lasts N+1 frames.
                    if (r_gap_cnt == '0) begin
                        w_nxt_state = ST_ACTIVE;
                        w_nxt_x     = X_SPAWN;
                        w_nxt_y     = w_spawn_y;
                        w_nxt_sel   = w_spawn_sel;
                        w_nxt_valid = 1'b1;
                    end else begin
                        w_nxt_gap = r_gap_cnt - GAP_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    // Only subtract when the result stays positive; anything
                    // that would reach or cross column 0 is a despawn.
                    if (r_x > w_step_x) begin
                        w_nxt_x = r_x - w_step_x;
                    end else begin
                        w_nxt_state  = ST_GAP;
                        w_nxt_gap    = w_gap_reload;
                        w_nxt_x      = X_PARKED;
                        w_nxt_y      = 10'd0;
                        w_nxt_sel    = SEL_NONE;
                        w_nxt_valid  = 1'b0;
                        w_nxt_passed = 1'b1;
                    end
                end
                default: w_nxt_state = ST_GAP;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // LFSR: free-running every cycle, independent of game_run, so the spawn
    // sequence depends on how long the player spends in each state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and simulation matches hardware.
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (restart) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // -------------------------------------------------------------------------
    // Wing animation: runs in both GAP and ACTIVE so the phase is continuous
    // across obstacles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anim_cnt <= '0;
            r_anim     <= 1'b0;
        end else if (restart) begin
            r_anim_cnt <= '0;
            r_anim     <= 1'b0;
        end else if (w_advance) begin
            if (r_anim_cnt == ANIM_LAST) begin
                r_anim_cnt <= '0;
                r_anim     <= ~r_anim;
            end else begin
                r_anim_cnt <= r_anim_cnt + ANIM_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM and obstacle output registers. restart outranks frame_tick, so a
    // restart on a despawn tick never produces a passed pulse.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_MIN;
            r_x       <= X_PARKED;
            r_y       <= 10'd0;
            r_sel     <= SEL_NONE;
            r_valid   <= 1'b0;
            r_passed  <= 1'b0;
        end else if (restart) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_MIN;
            r_x       <= X_PARKED;
            r_y       <= 10'd0;
            r_sel     <= SEL_NONE;
            r_valid   <= 1'b0;
            r_passed  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_gap_cnt <= w_nxt_gap;
            r_x       <= w_nxt_x;
            r_y       <= w_nxt_y;
            r_sel     <= w_nxt_sel;
            r_valid   <= w_nxt_valid;
            r_passed  <= w_nxt_passed;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign obstacle_x     = r_x;
    assign obstacle_y     = r_y;
    assign obstacle_sel   = r_sel;
    assign obstacle_valid = r_valid;
    assign animate_clk    = r_anim;
    assign passed         = r_passed;

endmodule

// File: tb/tb_obstacle_spawner.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawner
//
// Self-checking bench for obstacle_spawner. A behavioural model is stepped
// once per clock alongside the DUT; its expected outputs are queued when the
// inputs are driven and popped for comparison after the clock edge. Directed
// checks cover spawn latency, scroll timing, speed handling, freeze, wing
// period, asynchronous reset and restart.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_obstacle_spawner;

    localparam logic [15:0] SEED        = 16'hACE1;
    localparam int          MIN_GAP     = 30;
    localparam int          ANIM_FRAMES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       game_run;
    logic       restart;
    logic [3:0] speed;
    logic [9:0] obstacle_x;
    logic [9:0] obstacle_y;
    logic [3:0] obstacle_sel;
    logic       obstacle_valid;
    logic       animate_clk;
    logic       passed;

    obstacle_spawner dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .game_run       (game_run),
        .restart        (restart),
        .speed          (speed),
        .obstacle_x     (obstacle_x),
        .obstacle_y     (obstacle_y),
        .obstacle_sel   (obstacle_sel),
        .obstacle_valid (obstacle_valid),
        .animate_clk    (animate_clk),
        .passed         (passed)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [26:0] exp_q[$];
    bit          last_passed;

    // Reference model state
    logic [15:0] m_lfsr;
    bit          m_active;
    int          m_gap;
    int          m_x;
    int          m_y;
    logic [3:0]  m_sel;
    bit          m_valid;
    bit          m_anim;
    int          m_anim_cnt;
    bit          m_passed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        // Feedback is the parity of bits 15,13,12,10.
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [26:0] model_outputs();
        return {10'(m_x), 10'(m_y), m_sel, m_valid, m_anim, m_passed};
    endfunction

    function automatic logic [26:0] dut_outputs();
        return {obstacle_x, obstacle_y, obstacle_sel, obstacle_valid, animate_clk, passed};
    endfunction

    task automatic model_reset();
        m_lfsr     = SEED;
        m_active   = 1'b0;
        m_gap      = MIN_GAP;
        m_x        = 1023;
        m_y        = 0;
        m_sel      = 4'b0000;
        m_valid    = 1'b0;
        m_anim     = 1'b0;
        m_anim_cnt = 0;
        m_passed   = 1'b0;
    endtask

    // One clock edge of the model, using the inputs about to be sampled.
    task automatic model_clock(input bit tick, input bit rs);
        logic [15:0] cur;
        int          step;
        cur      = m_lfsr;
        m_passed = 1'b0;
        if (rs) begin
            model_reset();
            return;
        end
        m_lfsr = lfsr_next(m_lfsr);
        if (tick && game_run) begin
            if (m_anim_cnt == ANIM_FRAMES - 1) begin
                m_anim_cnt = 0;
                m_anim     = !m_anim;
            end else begin
                m_anim_cnt++;
            end
            if (!m_active) begin
                if (m_gap == 0) begin
                    m_active = 1'b1;
                    m_valid  = 1'b1;
                    m_x      = 640;
                    case (cur[2:0])
                        3'd0, 3'd1: begin m_sel = 4'b0100; m_y = 310; end
                        3'd2:       begin m_sel = 4'b0110; m_y = 310; end
                        3'd3:       begin m_sel = 4'b0101; m_y = 280; end
                        3'd4:       begin m_sel = 4'b0111; m_y = 280; end
                        default:    begin m_sel = 4'b1000; m_y = 200; end
                    endcase
                end else begin
                    m_gap--;
                end
            end else begin
                step = (speed == 4'd0) ? 1 : int'(speed);
                if (m_x > step) begin
                    m_x -= step;
                end else begin
                    m_active = 1'b0;
                    m_valid  = 1'b0;
                    m_x      = 1023;
                    m_y      = 0;
                    m_sel    = 4'b0000;
                    m_passed = 1'b1;
                    m_gap    = MIN_GAP + int'(cur[5:0]);
                end
            end
        end
    endtask

    task automatic do_cycle(input bit tick, input bit rs, input string tag);
        @(negedge clk);
        frame_tick = tick;
        restart    = rs;
        model_clock(tick, rs);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        restart    = 1'b0;
        check(tag, 32'(dut_outputs()), 32'(exp_q.pop_front()));
    endtask

    // A frame tick followed by one idle cycle, so the LFSR also moves
    // between frames.
    task automatic do_tick(input string tag);
        do_cycle(1'b1, 1'b0, tag);
        last_passed = passed;
        do_cycle(1'b0, 1'b0, tag);
    endtask

    task automatic wait_spawn(input string tag, output int n);
        n = 0;
        while (!obstacle_valid && n < 200) begin
            do_tick(tag);
            n++;
        end
        if (!obstacle_valid) check({tag, "_timeout"}, 32'(obstacle_valid), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        int          guard;
        int          exp_gap;
        int          held_x;
        logic [3:0]  held_sel;
        bit          held_anim;
        logic [9:0]  prev_x;
        bit          prev_anim;
        int          last_toggle;
        int          intervals;

        rst        = 1'b1;
        frame_tick = 1'b0;
        game_run   = 1'b1;
        restart    = 1'b0;
        speed      = 4'd4;
        last_passed = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'(dut_outputs()), 32'(model_outputs()));
        check("rst_lfsr", 32'(dut.r_lfsr), 32'(SEED));
        rst = 1'b0;

        // 1: first spawn after MIN_GAP+1 ticks
        wait_spawn("t1_gap", n);
        check("t1_spawn_ticks", n, 31);
        check("t1_spawn_x", 32'(obstacle_x), 32'd640);

        // 2: scroll at speed 4, despawn, random gap
        n = 0;
        last_passed = 1'b0;
        while (!last_passed && n < 400) begin
            do_tick("t2_scroll");
            n++;
        end
        check("t2_despawn_ticks", n, 160);
        exp_gap = m_gap;
        wait_spawn("t2_gap", n);
        check("t2_gap_ticks", n, exp_gap + 1);
        check("t2_gap_min", 32'(n >= 31), 32'd1);

        // 3: speed 0 acts as 1; speed 7 near the edge
        speed = 4'd15;
        guard = 0;
        while (m_active && m_x > 40 && guard < 100) begin
            do_tick("t3_fast");
            guard++;
        end
        speed  = 4'd0;
        prev_x = obstacle_x;
        do_tick("t3_speed0");
        check("t3_speed0_step", 32'(prev_x - obstacle_x), 32'd1);
        guard = 0;
        while (m_active && m_x > 10 && guard < 100) begin
            do_tick("t3_speed0");
            guard++;
        end
        speed = 4'd7;
        do_tick("t3_speed7");
        check("t3_speed7_x", 32'(obstacle_x), 32'd3);
        do_tick("t3_speed7");
        check("t3_speed7_despawn", 32'(last_passed), 32'd1);
        check("t3_parked_x", 32'(obstacle_x), 32'd1023);

        // 4: freeze with game_run low
        speed = 4'd4;
        wait_spawn("t4_gap", n);
        repeat (10) do_tick("t4_move");
        held_x    = m_x;
        held_sel  = m_sel;
        held_anim = m_anim;
        game_run  = 1'b0;
        repeat (50) do_tick("t4_frozen");
        check("t4_hold_x", 32'(obstacle_x), 32'(held_x));
        check("t4_hold_sel", 32'(obstacle_sel), 32'(held_sel));
        check("t4_hold_anim", 32'(animate_clk), 32'(held_anim));
        game_run = 1'b1;
        do_tick("t4_resume");
        check("t4_resume_x", 32'(obstacle_x), 32'(held_x - 4));

        // 5: wing phase toggles every ANIM_FRAMES ticks
        prev_anim   = animate_clk;
        last_toggle = -1;
        intervals   = 0;
        for (int i = 0; i < 48; i++) begin
            do_tick("t5_anim");
            if (animate_clk != prev_anim) begin
                if (last_toggle >= 0) begin
                    check("t5_anim_period", i - last_toggle, ANIM_FRAMES);
                    intervals++;
                end
                last_toggle = i;
            end
            prev_anim = animate_clk;
        end
        check("t5_toggles_seen", 32'(intervals >= 4), 32'd1);

        // 6a: asynchronous reset mid-flight
        wait_spawn("t6_gap", n);
        repeat (3) do_tick("t6_move");
        check("t6_pre_valid", 32'(obstacle_valid), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_async_rst", 32'(dut_outputs()), 32'(model_outputs()));
        check("t6_async_lfsr", 32'(dut.r_lfsr), 32'(SEED));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 6b: restart on a tick that would otherwise despawn
        speed = 4'd15;
        wait_spawn("t6_respawn", n);
        guard = 0;
        while (m_active && m_x > 15 && guard < 100) begin
            do_tick("t6_approach");
            guard++;
        end
        do_cycle(1'b1, 1'b1, "t6_restart");
        check("t6_restart_passed", 32'(passed), 32'd0);
        check("t6_restart_lfsr", 32'(dut.r_lfsr), 32'(SEED));
        do_cycle(1'b0, 1'b0, "t6_restart_idle");
        speed = 4'd4;
        wait_spawn("t6_after_restart", n);
        check("t6_restart_spawn_ticks", n, 31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
